njp_micro_div: RTL and testbench

- Sequential restoring divider; the inverse operation of the team's 4x4 shift-add multiplier.
- Divides an 8-bit unsigned dividend by a 4-bit unsigned divisor, producing an 8-bit quotient and a 4-bit remainder.
- Internally a small control FSM drives a shift/subtract datapath, one quotient bit per clock.
- Sits beside the multiplier in the micro top level; operands come from ui_in/uio_in and results go to uo_out/uio_out.

---
 rtl/njp_micro_pkg.sv | 17 +
 rtl/njp_div_ctrl.sv | 107 ++++++++++
 rtl/njp_micro_div.sv | 118 +++++++++++
 tb/tb_njp_micro_div.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/njp_micro_pkg.sv
// Shared definitions for the micro block: the divider state encoding,
// default operand widths and the step-counter width.
package njp_micro_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        ZERO = 3'd2,
        FAST = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/njp_div_ctrl.sv
// Control FSM for the restoring divider: step counter, busy/done flags and
// the load/step/finish strobes that steer the datapath in njp_micro_div.
// The zero-divisor and early-finish decisions are taken in the first CALC
// cycle, using the operands latched on the accept edge.
module njp_div_ctrl
    import njp_micro_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic div_zero,
    input  logic early,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic last,
    output logic fin_zero,
    output logic fin_fast
);

    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    div_state_t    state_r;
    logic [CW-1:0] count_r;
    logic          busy_r;
    logic          done_r;
    logic          first_s;

    assign first_s = (count_r == {CW{1'b0}});
    assign busy    = busy_r;
    assign done    = done_r;

    // Decode datapath strobes from the current state and counter.
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        fin_zero = 1'b0;
        fin_fast = 1'b0;
        case (state_r)
            IDLE: load = start;
            CALC: begin
                if (first_s && (div_zero || early)) begin
                    step = 1'b0;
                end else begin
                    step = 1'b1;
                    last = (count_r == LAST_CNT);
                end
            end
            ZERO:    fin_zero = 1'b1;
            FAST:    fin_fast = 1'b1;
            DONE:    load = 1'b0;
            default: load = 1'b0;
        endcase
    end

    // State register, step counter and registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                        count_r <= {CW{1'b0}};
                    end
                end
                CALC: begin
                    if (first_s && div_zero) begin
                        state_r <= ZERO;
                    end else if (first_s && early) begin
                        state_r <= FAST;
                    end else if (count_r == LAST_CNT) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ZERO, FAST: begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/njp_micro_div.sv
// Sequential restoring divider (DW-bit dividend / VW-bit divisor), one
// quotient bit per clock. Datapath registers live here; sequencing is in
// njp_div_ctrl.
// Optional build macro: NJP_DIV_EARLY_DONE_EN -- when defined, a dividend
// smaller than a nonzero divisor finishes through the FAST state.
module njp_micro_div
    import njp_micro_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // The partial remainder is always below the divisor, so its top bit of
    // the (VW+1)-bit working value is always zero and is not stored.
    logic [VW-1:0] p_r;
    logic [DW-1:0] q_r;
    logic [VW-1:0] div_r;

    logic [VW:0]   t_s;
    logic [VW:0]   diff_s;
    logic          ge_s;
    logic [VW-1:0] p_next_s;
    logic [DW-1:0] q_next_s;
    logic          div_zero_s;
    logic          early_s;
    logic          load_s;
    logic          step_s;
    logic          last_s;
    logic          fin_zero_s;
    logic          fin_fast_s;

    assign div_zero_s = (div_r == {VW{1'b0}});

`ifdef NJP_DIV_EARLY_DONE_EN
    assign early_s = (DW'(div_r) > q_r);
`else
    assign early_s = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract in
    // VW+1 bits; a borrow (MSB set) means the divisor did not fit.
    always_comb begin
        t_s      = {p_r, q_r[DW-1]};
        diff_s   = t_s - {1'b0, div_r};
        ge_s     = ~diff_s[VW];
        if (ge_s) begin
            p_next_s = diff_s[VW-1:0];
        end else begin
            p_next_s = t_s[VW-1:0];
        end
        q_next_s = {q_r[DW-2:0], ge_s};
    end

    njp_div_ctrl #(
        .DW (DW),
        .CW ($clog2(DW))
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .div_zero (div_zero_s),
        .early    (early_s),
        .busy     (busy),
        .done     (done),
        .load     (load_s),
        .step     (step_s),
        .last     (last_s),
        .fin_zero (fin_zero_s),
        .fin_fast (fin_fast_s)
    );

    // Work registers and result outputs; results change only on DONE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_r         <= {VW{1'b0}};
            q_r         <= {DW{1'b0}};
            div_r       <= {VW{1'b0}};
            quotient    <= {DW{1'b0}};
            remainder   <= {VW{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            if (load_s) begin
                p_r   <= {VW{1'b0}};
                q_r   <= dividend;
                div_r <= divisor;
            end else if (step_s) begin
                p_r <= p_next_s;
                q_r <= q_next_s;
            end

            if (last_s) begin
                quotient    <= q_next_s;
                remainder   <= p_next_s;
                div_by_zero <= 1'b0;
            end else if (fin_zero_s) begin
                quotient    <= {DW{1'b1}};
                remainder   <= {VW{1'b0}};
                div_by_zero <= 1'b1;
            end else if (fin_fast_s) begin
                quotient    <= {DW{1'b0}};
                remainder   <= q_r[VW-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_njp_micro_div.sv
// Self-checking bench for njp_micro_div: expected results are queued when a
// division is issued and compared when the DUT pulses done.
// Honours NJP_DIV_EARLY_DONE_EN for the expected latency.
module tb_njp_micro_div;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   busy_run = 0;
    logic [7:0] last_q = 8'd0;

    njp_micro_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1; e.lat = 2;
        end else begin
            e.q = a / {4'd0, b};
            e.r = 4'(a % {4'd0, b});
            e.dz = 1'b0;
            e.lat = 8;
`ifdef NJP_DIV_EARLY_DONE_EN
            if ({4'd0, b} > a) e.lat = 2;
`endif
        end
        return e;
    endfunction

    // Monitor: track busy run length and score every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !busy) busy_run = 0;
        else busy_run++;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dz);
                chk("latency", busy_run - 1, e.lat);
                if (e.b != 4'd0) begin
                    chk("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
                    chk("rem_lt_div", int'(remainder < e.b), 1);
                end
                last_q = e.q;
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_accept", busy, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("q_hold", quotient, last_q);
    endtask

    initial begin
        int saved;
        int seed;
        int idx;
        rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;

        issue(8'd200, 4'd7);  wait_done();
        issue(8'd255, 4'd15); wait_done();
        issue(8'd0, 4'd3);    wait_done();
        issue(8'd13, 4'd0);   wait_done();
        issue(8'd9, 4'd3);    wait_done();
        issue(8'd5, 4'd9);    wait_done();

        // start pulses while busy must be ignored
        saved = n_done;
        issue(8'd100, 4'd6);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 3 || k == 8) begin
                start = 1'b1; dividend = 8'd50; divisor = 4'd5;
            end else begin
                start = 1'b0;
            end
        end
        chk("ignored_busy", busy, 0);
        chk("ignored_done_count", n_done - saved, 1);
        chk("ignored_sb_empty", sb.size(), 0);

        // reset in the middle of a division
        saved = n_done;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        repeat (12) @(posedge clk);
        chk("abort_no_done", n_done - saved, 0);
        last_q = 8'd0;
        issue(8'd17, 4'd4); wait_done();

        // full operand sweep in a scrambled order
        seed = $urandom_range(0, 4095);
        for (int i = 0; i < 4096; i++) begin
            idx = (i * 2917 + seed) % 4096;
            issue(8'(idx >> 4), 4'(idx));
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
